rf_multiport: RTL and testbench

Parametrised register file with a configurable number of registered read ports, same-cycle write-to-read bypass, hard-wired constant registers and a sequential bulk-clear engine. It is the datapath register file the ALU reads operands from and writes results back to; write data is selected from three producer buses. It replaces the fixed two-port, destination-demuxed register file. Consumers now take read data directly, so there is no destination demux.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_multiport_if.sv | 49 ++++
 rtl/rf_clear_sweep.sv | 57 +++++
 rtl/rf_multiport.sv | 116 +++++++++++
 tb/tb_rf_multiport.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the multiport register file.
// Imported by the clear sweep engine and the register file top.
package rf_pkg;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    localparam logic [1:0] SRC_A = 2'd0;
    localparam logic [1:0] SRC_B = 2'd1;
    localparam logic [1:0] SRC_C = 2'd2;

    localparam int ZERO_ADDR = 0;
    localparam int ONES_ADDR = 1;

endpackage

// File: rtl/rf_multiport_if.sv
// Write/read/clear bundle between the datapath and the register file.
// master drives requests, slave returns read data and status.
interface rf_multiport_if #(
    parameter int N           = 8,
    parameter int addressBits = 3,
    parameter int READ_PORTS  = 2
);

    logic                                   writeEnable;
    logic [addressBits-1:0]                 writeAddress;
    logic [1:0]                             selectSource;
    logic [N-1:0]                           A;
    logic [N-1:0]                           B;
    logic [N-1:0]                           C;
    logic [READ_PORTS-1:0][addressBits-1:0] readAddress;
    logic [READ_PORTS-1:0][N-1:0]           readData;
    logic                                   clearStart;
    logic                                   busy;
    logic                                   writeDropped;

    modport master (
        output writeEnable,
        output writeAddress,
        output selectSource,
        output A,
        output B,
        output C,
        output readAddress,
        output clearStart,
        input  readData,
        input  busy,
        input  writeDropped
    );

    modport slave (
        input  writeEnable,
        input  writeAddress,
        input  selectSource,
        input  A,
        input  B,
        input  C,
        input  readAddress,
        input  clearStart,
        output readData,
        output busy,
        output writeDropped
    );

endinterface

// File: rtl/rf_clear_sweep.sv
// Bulk-clear engine: walks storage addresses 2..DEPTH-1,
// zeroing one register per cycle, then returns to IDLE.
module rf_clear_sweep
    import rf_pkg::*;
#(
    parameter int addressBits = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clearStart,
    output logic                   busy,
    output logic                   clearWriteEnable,
    output logic [addressBits-1:0] clearAddress
);

    localparam int DEPTH = 1 << addressBits;

    localparam logic [addressBits-1:0] FIRST =
        addressBits'(2);
    localparam logic [addressBits-1:0] LAST =
        addressBits'(DEPTH - 1);

    state_t                 state;
    logic [addressBits-1:0] count;

    // Sweep FSM; clearStart is ignored once a sweep is running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= FIRST;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clearStart) begin
                        state <= CLEAR;
                        count <= FIRST;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (count == LAST) begin
                        state <= IDLE;
                        count <= FIRST;
                        busy  <= 1'b0;
                    end else begin
                        count <= count + addressBits'(1);
                    end
                end
            endcase
        end
    end

    assign clearWriteEnable = (state == CLEAR);
    assign clearAddress     = count;

endmodule

// File: rtl/rf_multiport.sv
// Datapath register file: constant regs 0/1, one muxed write
// port, bypassed registered read ports and a bulk-clear engine.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int N           = 8,
    parameter int addressBits = 3,
    parameter int READ_PORTS  = 2
) (
    input logic           clk,
    input logic           rst,
    rf_multiport_if.slave bus
);

    localparam int DEPTH = 1 << addressBits;

    typedef logic [addressBits-1:0] addr_t;

    localparam addr_t ZERO_A = addr_t'(ZERO_ADDR);
    localparam addr_t ONES_A = addr_t'(ONES_ADDR);

    function automatic logic isStorage(input addr_t a);
        return (a != ZERO_A) && (a != ONES_A);
    endfunction

    logic         clearWe;
    addr_t        clearAddr;
    logic         sweepBusy;
    logic [N-1:0] srcData;
    logic         userWe;
    logic         we;
    addr_t        wa;
    logic [N-1:0] wd;

    logic [N-1:0]                 mem [DEPTH];
    logic [READ_PORTS-1:0][N-1:0] rdNext;

    rf_clear_sweep #(
        .addressBits(addressBits)
    ) u_sweep (
        .clk              (clk),
        .rst              (rst),
        .clearStart       (bus.clearStart),
        .busy             (sweepBusy),
        .clearWriteEnable (clearWe),
        .clearAddress     (clearAddr)
    );

    assign bus.busy = sweepBusy;

    // Write source mux; code 3 falls back to A.
    always_comb begin
        srcData = bus.A;
        case (bus.selectSource)
            SRC_B:   srcData = bus.B;
            SRC_C:   srcData = bus.C;
            default: srcData = bus.A;
        endcase
    end

    assign userWe = bus.writeEnable && !clearWe
                 && isStorage(bus.writeAddress);

    // Single effective write port: the sweep owns it in CLEAR.
    always_comb begin
        we = userWe;
        wa = bus.writeAddress;
        wd = srcData;
        if (clearWe) begin
            we = 1'b1;
            wa = clearAddr;
            wd = '0;
        end
    end

    // Storage array; entries 0 and 1 are never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        addr_t ra;
        assign ra = bus.readAddress[p];
        assign rdNext[p] =
            (ra == ZERO_A)      ? {N{1'b0}} :
            (ra == ONES_A)      ? {N{1'b1}} :
            (we && (wa == ra))  ? wd        :
                                  mem[ra];
    end

    // Registered read data for all ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.readData <= '0;
        end else begin
            bus.readData <= rdNext;
        end
    end

    // Flags a user write to storage discarded by the sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.writeDropped <= 1'b0;
        end else begin
            bus.writeDropped <= bus.writeEnable && clearWe
                             && isStorage(bus.writeAddress);
        end
    end

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: vector table plus
// hand-written clear / reset sequences, scoreboard queue.
module tb_rf_multiport;

    localparam int N  = 8;
    localparam int AB = 3;
    localparam int RP = 2;

    logic clk;
    logic rst;

    rf_multiport_if #(
        .N(N), .addressBits(AB), .READ_PORTS(RP)
    ) bus ();

    rf_multiport #(
        .N(N), .addressBits(AB), .READ_PORTS(RP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic       we;
        logic [2:0] wa;
        logic [1:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] c;
        logic       cs;
        logic [2:0] ra0;
        logic [2:0] ra1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ed;
    } vec_t;

    typedef struct {
        logic [7:0] e0;
        logic [7:0] e1;
        logic       ed;
    } exp_t;

    exp_t exq[$];
    vec_t tbl[$];

    int checks = 0;
    int errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic       we,
        input logic [2:0] wa,
        input logic [1:0] sel,
        input logic [7:0] d,
        input logic       cs,
        input logic [2:0] r0,
        input logic [2:0] r1,
        input logic [7:0] e0,
        input logic [7:0] e1,
        input logic       ed
    );
        vec_t v;
        v.we  = we;
        v.wa  = wa;
        v.sel = sel;
        v.a   = d ^ 8'h81;
        v.b   = d ^ 8'h42;
        v.c   = d ^ 8'h24;
        case (sel)
            2'd1:    v.b = d;
            2'd2:    v.c = d;
            default: v.a = d;
        endcase
        v.cs  = cs;
        v.ra0 = r0;
        v.ra1 = r1;
        v.e0  = e0;
        v.e1  = e1;
        v.ed  = ed;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        bus.writeEnable    = v.we;
        bus.writeAddress   = v.wa;
        bus.selectSource   = v.sel;
        bus.A              = v.a;
        bus.B              = v.b;
        bus.C              = v.c;
        bus.clearStart     = v.cs;
        bus.readAddress[0] = v.ra0;
        bus.readAddress[1] = v.ra1;
    endtask

    task automatic run(input vec_t v, input string nm);
        exp_t x;
        exp_t e;
        drive(v);
        x.e0 = v.e0;
        x.e1 = v.e1;
        x.ed = v.ed;
        exq.push_back(x);
        tick();
        e = exq.pop_front();
        chk({nm, "/rd0"}, 32'(bus.readData[0]), 32'(e.e0));
        chk({nm, "/rd1"}, 32'(bus.readData[1]), 32'(e.e1));
        chk({nm, "/drop"}, 32'(bus.writeDropped), 32'(e.ed));
    endtask

    initial begin
        vec_t       idle;
        logic [2:0] ad;
        logic [2:0] nx;
        logic [7:0] ex;
        int         busyCnt;

        idle = mk(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 8; i++) begin
            logic [2:0] r0;
            logic [2:0] r1;
            r0 = 3'(i);
            r1 = 3'(7 - i);
            tbl.push_back(mk(0, 0, 0, 8'h00, 0, r0, r1,
                (r0 == 3'd1) ? 8'hFF : 8'h00,
                (r1 == 3'd1) ? 8'hFF : 8'h00, 0));
        end
        tbl.push_back(mk(1, 3, 0, 8'h5A, 0, 3, 0, 8'h5A, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 3, 8'h00, 8'h5A, 0));
        tbl.push_back(mk(1, 4, 1, 8'h11, 0, 4, 3, 8'h11, 8'h5A, 0));
        tbl.push_back(mk(1, 5, 2, 8'h22, 0, 5, 4, 8'h22, 8'h11, 0));
        tbl.push_back(mk(1, 6, 3, 8'h33, 0, 6, 5, 8'h33, 8'h22, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 6, 4, 8'h33, 8'h11, 0));
        tbl.push_back(mk(1, 0, 0, 8'hFF, 0, 0, 1, 8'h00, 8'hFF, 0));
        tbl.push_back(mk(1, 1, 0, 8'h00, 0, 1, 0, 8'hFF, 8'h00, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'hFF, 0));
        tbl.push_back(mk(1, 2, 0, 8'h10, 0, 2, 2, 8'h10, 8'h10, 0));
        tbl.push_back(mk(1, 2, 1, 8'h20, 0, 2, 3, 8'h20, 8'h5A, 0));
        tbl.push_back(mk(0, 0, 0, 8'h00, 0, 2, 6, 8'h20, 8'h33, 0));

        rst = 1'b0;
        drive(idle);
        #1 rst = 1'b1;
        #1;
        chk("reset/rd0", 32'(bus.readData[0]), 32'h0);
        chk("reset/rd1", 32'(bus.readData[1]), 32'h0);
        chk("reset/busy", 32'(bus.busy), 32'h0);
        chk("reset/drop", 32'(bus.writeDropped), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            run(tbl[i], $sformatf("vec%0d", i));
        end

        // bulk clear with port 0 tracking the sweep address
        for (int a = 2; a < 8; a++) begin
            ad = 3'(a);
            run(mk(1, ad, 0, 8'hA5, 0, ad, 0, 8'hA5, 8'h00, 0),
                "fill");
        end
        run(mk(0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 8'hFF, 0), "clr_go");
        chk("clr_go/busy", 32'(bus.busy), 32'h1);
        busyCnt = 1;
        for (int j = 0; j < 6; j++) begin
            ad = 3'(2 + j);
            nx = (j < 5) ? 3'(3 + j) : 3'd0;
            ex = (j < 5) ? 8'hA5 : 8'h00;
            run(mk(0, 0, 0, 8'h00, 0, ad, nx, 8'h00, ex, 0),
                $sformatf("sweep%0d", j));
            chk($sformatf("sweep%0d/busy", j),
                32'(bus.busy), (j < 5) ? 32'h1 : 32'h0);
            if (bus.busy) busyCnt++;
        end
        chk("clr/busy_cycles", 32'(busyCnt), 32'd6);
        run(mk(0, 0, 0, 8'h00, 0, 2, 3, 8'h00, 8'h00, 0), "clr_rd");
        run(mk(0, 0, 0, 8'h00, 0, 4, 5, 8'h00, 8'h00, 0), "clr_rd");
        run(mk(0, 0, 0, 8'h00, 0, 6, 7, 8'h00, 8'h00, 0), "clr_rd");

        // writes and repeated clearStart during a sweep
        run(mk(1, 7, 0, 8'hA5, 0, 7, 0, 8'hA5, 8'h00, 0), "pre7");
        run(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0), "wc_go");
        run(mk(1, 7, 0, 8'h77, 0, 1, 0, 8'hFF, 8'h00, 1), "wc_w7");
        run(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0), "wc_cs");
        run(mk(1, 1, 0, 8'h55, 1, 1, 0, 8'hFF, 8'h00, 0), "wc_w1");
        run(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0), "wc_cs");
        chk("wc/busy_mid", 32'(bus.busy), 32'h1);
        run(mk(0, 0, 0, 8'h00, 0, 7, 0, 8'hA5, 8'h00, 0), "wc_c6");
        chk("wc/busy_last", 32'(bus.busy), 32'h1);
        run(mk(0, 0, 0, 8'h00, 0, 7, 0, 8'h00, 8'h00, 0), "wc_c7");
        chk("wc/busy_end", 32'(bus.busy), 32'h0);
        run(mk(1, 2, 0, 8'h44, 0, 2, 7, 8'h44, 8'h00, 0), "wc_idle");
        chk("wc/busy_idle", 32'(bus.busy), 32'h0);

        // reset in the third sweep cycle
        run(mk(1, 5, 0, 8'h55, 0, 5, 2, 8'h55, 8'h44, 0), "rs_f5");
        run(mk(1, 6, 1, 8'h66, 0, 6, 0, 8'h66, 8'h00, 0), "rs_f6");
        run(mk(1, 7, 2, 8'h88, 0, 7, 5, 8'h88, 8'h55, 0), "rs_f7");
        run(mk(0, 0, 0, 8'h00, 1, 6, 7, 8'h66, 8'h88, 0), "rs_go");
        run(mk(0, 0, 0, 8'h00, 0, 2, 5, 8'h00, 8'h55, 0), "rs_c2");
        run(mk(0, 0, 0, 8'h00, 0, 3, 6, 8'h00, 8'h66, 0), "rs_c3");
        chk("rs/busy_pre", 32'(bus.busy), 32'h1);
        drive(mk(0, 0, 0, 8'h00, 0, 1, 5, 8'h00, 8'h00, 0));
        rst = 1'b1;
        #1;
        chk("rs/busy_async", 32'(bus.busy), 32'h0);
        chk("rs/rd0_async", 32'(bus.readData[0]), 32'h0);
        chk("rs/rd1_async", 32'(bus.readData[1]), 32'h0);
        chk("rs/drop_async", 32'(bus.writeDropped), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        run(mk(1, 6, 2, 8'h3C, 0, 1, 6, 8'hFF, 8'h3C, 0), "rs_w6");
        chk("rs/busy_after", 32'(bus.busy), 32'h0);
        run(mk(0, 0, 0, 8'h00, 0, 7, 5, 8'h00, 8'h00, 0), "rs_rd");
        run(mk(0, 0, 0, 8'h00, 0, 6, 2, 8'h3C, 8'h00, 0), "rs_rd");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
